// File: rtl/vga_fetch_ctrl_pkg.sv
// Shared definitions for the VGA framebuffer fetch sequencer: FSM encoding and AXI4 constants.
package vga_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_WAIT_SPC = 2'd1,
    FETCH_ADDR     = 2'd2,
    FETCH_DATA     = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/vga_fetch_ctrl.sv
// Framebuffer fetch sequencer: walks the frame with single-outstanding AXI4 INCR read bursts
// and pushes returned beats into the pixel FIFO.
module vga_fetch_ctrl
  import vga_fetch_ctrl_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [AXI_ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]      frame_words_i,
  input  logic                  frame_start_i,
  input  logic [CNT_W-1:0]      fifo_free_i,
  output logic                  fifo_wr_en_o,
  output logic [AXI_DATA_W-1:0] fifo_wr_data_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [AXI_ADDR_W-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic [AXI_ID_W-1:0]   arid_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [AXI_DATA_W-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned BPB       = AXI_DATA_W / 8;
  localparam int unsigned SIZE_LOG2 = $clog2(BPB);
  localparam logic [2:0]  AR_SIZE   = 3'(SIZE_LOG2);

  fetch_state_e          r_state, w_state_d;
  logic [AXI_ADDR_W-1:0] r_ptr, w_ptr_d;
  logic [CNT_W-1:0]      r_rem, w_rem_d;
  logic [8:0]            r_len, w_len_d;
  logic                  r_restart_pend, w_restart_d;
  logic                  r_err, w_err_d;

  logic [12:0] w_bytes_to_4k;
  logic [31:0] w_words_to_4k;
  logic [31:0] w_len_c;
  logic [8:0]  w_arlen;
  logic        w_beat;
  logic        w_keep;
  logic        w_reload_ok;

  // Burst length is the smallest of the max burst, the words left and the room to the 4KB page end.
  assign w_bytes_to_4k = 13'h1000 - {1'b0, r_ptr[11:0]};
  assign w_words_to_4k = 32'(w_bytes_to_4k >> SIZE_LOG2);

  always_comb begin
    w_len_c = 32'(BURST_LEN);
    if (32'(r_rem) < w_len_c) w_len_c = 32'(r_rem);
    if (w_words_to_4k < w_len_c) w_len_c = w_words_to_4k;
  end

  assign w_beat      = (r_state == FETCH_DATA) && rvalid_i;
  // Beats of an abandoned burst are drained without being written.
  assign w_keep      = w_beat && !r_restart_pend && (r_rem != '0);
  assign w_reload_ok = en_i && (frame_words_i != '0);

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_rem_d     = r_rem;
    w_len_d     = r_len;
    w_restart_d = r_restart_pend;
    w_err_d     = r_err;

    if (frame_start_i) w_err_d = 1'b0;
    if (w_beat && (rresp_i != AXI_RESP_OKAY)) w_err_d = 1'b1;

    unique case (r_state)
      FETCH_IDLE: begin
        if (frame_start_i && w_reload_ok) begin
          w_ptr_d   = base_addr_i;
          w_rem_d   = frame_words_i;
          w_state_d = FETCH_WAIT_SPC;
        end
      end
      FETCH_WAIT_SPC: begin
        if (frame_start_i) begin
          w_ptr_d   = base_addr_i;
          w_rem_d   = frame_words_i;
          w_state_d = w_reload_ok ? FETCH_WAIT_SPC : FETCH_IDLE;
        end else if (!en_i) begin
          w_state_d = FETCH_IDLE;
        end else if (32'(fifo_free_i) >= w_len_c) begin
          w_len_d   = w_len_c[8:0];
          w_state_d = FETCH_ADDR;
        end
      end
      FETCH_ADDR: begin
        if (frame_start_i) w_restart_d = 1'b1;
        if (arready_i) w_state_d = FETCH_DATA;
      end
      FETCH_DATA: begin
        if (frame_start_i) w_restart_d = 1'b1;
        if (w_keep) begin
          w_ptr_d = r_ptr + AXI_ADDR_W'(BPB);
          w_rem_d = r_rem - CNT_W'(1);
        end
        if (w_beat && rlast_i) begin
          if (r_restart_pend || frame_start_i) begin
            w_restart_d = 1'b0;
            w_ptr_d     = base_addr_i;
            w_rem_d     = frame_words_i;
            w_state_d   = w_reload_ok ? FETCH_WAIT_SPC : FETCH_IDLE;
          end else if (w_rem_d == '0 || !en_i) begin
            w_state_d = FETCH_IDLE;
          end else begin
            w_state_d = FETCH_WAIT_SPC;
          end
        end
      end
      default: w_state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= FETCH_IDLE;
      r_ptr          <= '0;
      r_rem          <= '0;
      r_len          <= '0;
      r_restart_pend <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_ptr          <= w_ptr_d;
      r_rem          <= w_rem_d;
      r_len          <= w_len_d;
      r_restart_pend <= w_restart_d;
      r_err          <= w_err_d;
    end
  end

  assign w_arlen = r_len - 9'd1;

  assign arvalid_o      = (r_state == FETCH_ADDR);
  assign araddr_o       = arvalid_o ? r_ptr : '0;
  assign arlen_o        = arvalid_o ? w_arlen[7:0] : 8'd0;
  assign arsize_o       = arvalid_o ? AR_SIZE : 3'd0;
  assign arburst_o      = arvalid_o ? AXI_BURST_INCR : 2'b00;
  assign arid_o         = AXI_ID_W'(AXI_ID);
  assign rready_o       = (r_state == FETCH_DATA);
  assign fifo_wr_en_o   = w_keep;
  assign fifo_wr_data_o = w_keep ? rdata_i : '0;
  assign busy_o         = (r_state != FETCH_IDLE);
  assign err_o          = r_err;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Randomized bench for vga_fetch_ctrl: AXI slave with address-derived data plus frame-level model.
module tb_vga_fetch_ctrl;

  localparam int unsigned CNT_W = 20;
  localparam int          BURST = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              en_i;
  logic [31:0]       base_addr_i;
  logic [CNT_W-1:0]  frame_words_i;
  logic              frame_start_i;
  logic [CNT_W-1:0]  fifo_free_i;
  logic              fifo_wr_en_o;
  logic [31:0]       fifo_wr_data_o;
  logic              arvalid_o;
  logic              arready_i;
  logic [31:0]       araddr_o;
  logic [7:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic [3:0]        arid_o;
  logic              rvalid_i;
  logic              rready_o;
  logic [31:0]       rdata_i;
  logic [1:0]        rresp_i;
  logic              rlast_i;
  logic              busy_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  vga_fetch_ctrl #(
    .AXI_ADDR_W(32),
    .AXI_DATA_W(32),
    .AXI_ID_W  (4),
    .AXI_ID    (0),
    .BURST_LEN (BURST),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .base_addr_i   (base_addr_i),
    .frame_words_i (frame_words_i),
    .frame_start_i (frame_start_i),
    .fifo_free_i   (fifo_free_i),
    .fifo_wr_en_o  (fifo_wr_en_o),
    .fifo_wr_data_o(fifo_wr_data_o),
    .arvalid_o     (arvalid_o),
    .arready_i     (arready_i),
    .araddr_o      (araddr_o),
    .arlen_o       (arlen_o),
    .arsize_o      (arsize_o),
    .arburst_o     (arburst_o),
    .arid_o        (arid_o),
    .rvalid_i      (rvalid_i),
    .rready_o      (rready_o),
    .rdata_i       (rdata_i),
    .rresp_i       (rresp_i),
    .rlast_i       (rlast_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  logic [31:0] exp_data[$];

  bit          burst_act;
  logic [31:0] s_addr;
  int          s_left;

  // Whole-frame expectation: burst list split at max length and 4KB pages, and the word stream.
  task automatic build_exp(input logic [31:0] base, input int words);
    logic [31:0] a;
    int rem, len, to4k;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_data.delete();
    for (int i = 0; i < words; i++) exp_data.push_back(word_at(base + 32'(4 * i)));
    a   = base;
    rem = words;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 32'd4096)) / 4;
      len  = BURST;
      if (rem < len) len = rem;
      if (to4k < len) len = to4k;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(len);
      a   = a + 32'(4 * len);
      rem = rem - len;
    end
  endtask

  task automatic run_frame(input logic [31:0] base, input int words, input int free,
                           input int free_lo, input int raise_cyc, input int restart_after,
                           input int err_beat, input int rst_after);
    int cyc, pushes, beat_idx, first_arv, exp_lat;
    bit done, restarted, exp_err, aborted, any_ar;
    base_addr_i   = base;
    frame_words_i = CNT_W'(words);
    build_exp(base, words);
    cyc = 0; pushes = 0; beat_idx = 0; first_arv = -1;
    done = 0; restarted = 0; exp_err = 0; aborted = 0;
    burst_act = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk_i); #1;
      frame_start_i = (cyc == 0);
      fifo_free_i   = CNT_W'((cyc < raise_cyc) ? free_lo : free);
      arready_i     = ($urandom_range(0, 3) != 0);
      rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; rdata_i = '0;
      if (rst_after >= 0 && pushes == rst_after) begin
        rst_i = 1'b1;
        #1;
        check_eq("rst_outputs", {arvalid_o, rready_o, fifo_wr_en_o, busy_o, err_o, |araddr_o,
                                 |arlen_o, |arsize_o, |arburst_o, |fifo_wr_data_o}, 10'd0);
        aborted = 1;
        done    = 1;
      end else begin
        if (restart_after > 0 && !restarted && pushes == restart_after) begin
          frame_start_i = 1'b1;
          restarted     = 1;
          exp_err       = 0;
          build_exp(base, words);
        end else if (burst_act && $urandom_range(0, 3) != 0) begin
          rvalid_i = 1'b1;
          rdata_i  = word_at(s_addr);
          rlast_i  = (s_left == 1);
          rresp_i  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        end
        @(negedge clk_i);
        if (cyc == 1) check_eq("start_state", {busy_o, err_o}, 2'b10);
        if (arvalid_o && first_arv < 0) first_arv = cyc;
        if (arvalid_o && arready_i) begin
          check_eq("ar_expected", exp_ar_addr.size() != 0, 1);
          if (exp_ar_addr.size() != 0) begin
            check_eq("ar_addr", araddr_o, exp_ar_addr.pop_front());
            check_eq("ar_len", arlen_o, exp_ar_len.pop_front() - 1);
            check_eq("ar_fixed", {arsize_o, arburst_o, arid_o}, {3'd2, 2'b01, 4'd0});
          end
          burst_act = 1;
          s_addr    = araddr_o;
          s_left    = int'(arlen_o) + 1;
        end
        if (rvalid_i && rready_o) begin
          if (fifo_wr_en_o) begin
            check_eq("push_expected", exp_data.size() != 0, 1);
            if (exp_data.size() != 0) check_eq("push_data", fifo_wr_data_o, exp_data.pop_front());
            pushes++;
          end
          if (rresp_i != 2'b00) exp_err = 1;
          s_addr = s_addr + 32'd4;
          s_left--;
          beat_idx++;
          if (s_left == 0) burst_act = 0;
        end else begin
          check_eq("stray_push", fifo_wr_en_o, 0);
        end
        done = (cyc >= 2) && !busy_o && !burst_act && exp_ar_addr.size() == 0 &&
               exp_data.size() == 0;
        cyc++;
      end
    end
    frame_start_i = 1'b0;
    if (aborted) begin
      @(posedge clk_i); #1;
      arready_i = 1'b1;
      rvalid_i  = 1'b0;
      @(posedge clk_i); #1;
      rst_i  = 1'b0;
      any_ar = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_i);
        any_ar = any_ar | arvalid_o | busy_o;
      end
      check_eq("rst_no_ar", any_ar, 0);
      burst_act = 0;
    end else begin
      exp_lat = (raise_cyc > 1) ? raise_cyc + 1 : 2;
      check_eq("frame_done", done, 1);
      check_eq("ar_latency", first_arv, exp_lat);
      check_eq("push_count", pushes, words + (restarted ? restart_after : 0));
      check_eq("ar_left", exp_ar_addr.size(), 0);
      check_eq("err_end", err_o, exp_err);
    end
    arready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    int w, f, eb;
    rst_i = 1'b1; en_i = 1'b1; base_addr_i = '0; frame_words_i = '0; frame_start_i = 1'b0;
    fifo_free_i = '0; arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00;
    rlast_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("reset_outputs", {arvalid_o, rready_o, fifo_wr_en_o, busy_o, err_o, araddr_o,
                               arlen_o, arsize_o, arburst_o}, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Disabled fetch and an empty frame both leave the sequencer idle.
    base_addr_i = 32'h1000; frame_words_i = CNT_W'(8); fifo_free_i = CNT_W'(64);
    en_i = 1'b0; frame_start_i = 1'b1;
    @(posedge clk_i); #1; frame_start_i = 1'b0;
    @(negedge clk_i); check_eq("en_low_idle", busy_o, 0);
    @(posedge clk_i); #1; en_i = 1'b1; frame_words_i = '0; frame_start_i = 1'b1;
    @(posedge clk_i); #1; frame_start_i = 1'b0;
    @(negedge clk_i); check_eq("zero_words_idle", busy_o, 0);

    run_frame(32'h0000_1000, 40, 64, 64, 0, 0, -1, -1);
    run_frame(32'h0000_0FF8,  8, 64, 64, 0, 0, -1, -1);
    run_frame(32'h0000_2000, 16, 16, 10, 8, 0, -1, -1);
    run_frame(32'h0000_3000, 32, 64, 64, 0, 5, -1, -1);
    run_frame(32'h0000_4000, 20, 64, 64, 0, 0,  3, -1);
    run_frame(32'hFFFF_FFF0, 12, 64, 64, 0, 0, -1, -1);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 0) b = {$urandom(), 2'b00};
      else b = {$urandom(), 12'h000} - 32'(4 * $urandom_range(1, 20));
      w  = $urandom_range(1, 70);
      f  = $urandom_range(16, 64);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w - 1) : -1;
      run_frame(b, w, f, f, 0, 0, eb, -1);
    end

    run_frame(32'h0000_5000, 64, 64, 64, 0, 0, -1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
